lvds_rx_word_align: RTL and testbench

LVDS_RX_WORD_ALIGN -- requirements
Module: lvds_rx_word_align

---
 rtl/lvds_rx_word_align.sv | 127 ++++++++++++
 tb/tb_lvds_rx_word_align.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_word_align.sv
// Word aligner for a 7:1 LVDS receiver: bit-slips the deserializer until the
// clock lane shows the expected pattern, then passes lane data while locked.
module lvds_rx_word_align #(
    parameter int         LANES       = 4,
    parameter logic [6:0] CLK_PATTERN = 7'b1100011,
    parameter int         MATCH_CNT   = 16,
    parameter int         SLIP_WAIT   = 4,
    parameter int         ERR_LIMIT   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock,
    input  logic [6:0]         clk_word,
    input  logic [7*LANES-1:0] data_in,
    output logic               bitslip,
    output logic               aligned,
    output logic [7*LANES-1:0] data_out,
    output logic               data_valid,
    output logic               align_err
);

    localparam int MW = $clog2(MATCH_CNT) + 1;
    localparam int WW = $clog2(SLIP_WAIT) + 1;
    localparam int EW = $clog2(ERR_LIMIT) + 1;

    localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_CNT - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT - 1);
    localparam logic [EW-1:0] ERR_LAST   = EW'(ERR_LIMIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SLIP,
        WAIT,
        VERIFY,
        LOCKED
    } state_t;

    state_t state, state_nx;

    logic [MW-1:0] match_cnt;
    logic [WW-1:0] wait_cnt;
    logic [EW-1:0] err_cnt;
    logic [2:0]    slip_cnt;
    logic          pat_match;

    assign pat_match = (clk_word == CLK_PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pll_lock) state_nx = CHECK;
            CHECK:   state_nx = pat_match ? ((MATCH_CNT > 1) ? VERIFY : LOCKED) : SLIP;
            SLIP:    state_nx = WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) state_nx = CHECK;
            VERIFY: begin
                if (!pat_match) begin
                    state_nx = SLIP;
                end else if (match_cnt == MATCH_LAST) begin
                    state_nx = LOCKED;
                end
            end
            LOCKED:  if (!pat_match && err_cnt == ERR_LAST) state_nx = CHECK;
            default: state_nx = IDLE;
        endcase
        // Loss of PLL lock overrides every other transition.
        if (!pll_lock) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
            wait_cnt  <= '0;
            err_cnt   <= '0;
            slip_cnt  <= '0;
            align_err <= 1'b0;
        end else if (!pll_lock) begin
            match_cnt <= '0;
            wait_cnt  <= '0;
            err_cnt   <= '0;
            slip_cnt  <= '0;
            align_err <= 1'b0;
        end else begin
            align_err <= 1'b0;
            wait_cnt  <= (state == WAIT && state_nx == WAIT) ? wait_cnt + 1'b1 : '0;
            err_cnt   <= (state == LOCKED && state_nx == LOCKED && !pat_match) ?
                         err_cnt + 1'b1 : '0;
            if (state_nx == VERIFY) begin
                match_cnt <= (state == VERIFY) ? match_cnt + 1'b1 : MW'(1);
            end else begin
                match_cnt <= '0;
            end
            // Seventh slip without a match reports once and restarts the count.
            if (state_nx == LOCKED && state != LOCKED) begin
                slip_cnt <= '0;
            end else if (state == SLIP) begin
                if (slip_cnt == 3'd6) begin
                    slip_cnt  <= '0;
                    align_err <= 1'b1;
                end else begin
                    slip_cnt <= slip_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else begin
            data_out <= (state_nx == LOCKED) ? data_in : '0;
        end
    end

    assign bitslip    = (state == SLIP);
    assign aligned    = (state == LOCKED);
    assign data_valid = (state == LOCKED);

endmodule

// File: tb/tb_lvds_rx_word_align.sv
// Bench for lvds_rx_word_align: directed scenarios plus a per-cycle
// comparison against a behavioural alignment model.
module tb_lvds_rx_word_align;

    localparam int         LANES     = 4;
    localparam int         W         = 7 * LANES;
    localparam logic [6:0] PAT       = 7'b1100011;
    localparam int         MATCH_CNT = 16;
    localparam int         SLIP_WAIT = 4;
    localparam int         ERR_LIMIT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pll_lock = 1'b0;
    logic [6:0]   clk_word = '0;
    logic [W-1:0] data_in = '0;
    logic         bitslip, aligned, data_valid, align_err;
    logic [W-1:0] data_out;

    int checks = 0;
    int errors = 0;
    bit rot_en = 1'b0;

    lvds_rx_word_align #(
        .LANES      (LANES),
        .CLK_PATTERN(PAT),
        .MATCH_CNT  (MATCH_CNT),
        .SLIP_WAIT  (SLIP_WAIT),
        .ERR_LIMIT  (ERR_LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .clk_word  (clk_word),
        .data_in   (data_in),
        .bitslip   (bitslip),
        .aligned   (aligned),
        .data_out  (data_out),
        .data_valid(data_valid),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks the search/verify/lock progress in plain counters.
    bit           m_idle = 1'b1, m_chk = 1'b0, m_slip = 1'b0, m_lock = 1'b0, m_err = 1'b0;
    int           m_settle = 0, m_run = 0, m_errs = 0, m_nslip = 0;
    logic [W-1:0] m_dout = '0;

    function automatic void m_clear();
        m_idle = 1'b1; m_chk = 1'b0; m_slip = 1'b0; m_lock = 1'b0; m_err = 1'b0;
        m_settle = 0; m_run = 0; m_errs = 0; m_nslip = 0; m_dout = '0;
    endfunction

    function automatic void m_step(bit pll, bit hit, logic [W-1:0] din);
        if (!pll) begin
            m_clear();
            return;
        end
        m_err = 1'b0;
        if (m_idle) begin
            m_idle = 1'b0; m_chk = 1'b1;
        end else if (m_slip) begin
            m_slip = 1'b0;
            m_nslip++;
            if (m_nslip == 7) begin m_nslip = 0; m_err = 1'b1; end
            m_settle = SLIP_WAIT;
        end else if (m_settle > 0) begin
            m_settle--;
            if (m_settle == 0) m_chk = 1'b1;
        end else if (m_chk) begin
            m_chk = 1'b0;
            if (hit) begin
                m_run = 1;
                if (m_run >= MATCH_CNT) begin m_lock = 1'b1; m_run = 0; m_nslip = 0; end
            end else begin
                m_slip = 1'b1;
            end
        end else if (m_lock) begin
            if (hit) m_errs = 0; else m_errs++;
            if (m_errs == ERR_LIMIT) begin m_lock = 1'b0; m_errs = 0; m_chk = 1'b1; end
        end else begin
            if (hit) begin
                m_run++;
                if (m_run == MATCH_CNT) begin m_lock = 1'b1; m_run = 0; m_nslip = 0; end
            end else begin
                m_run = 0; m_slip = 1'b1;
            end
        end
        m_dout = m_lock ? din : '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_clear();
        else        m_step(pll_lock, clk_word == PAT, data_in);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_bitslip", bitslip, 0);
            chk("rst_aligned", aligned, 0);
            chk("rst_valid", data_valid, 0);
            chk("rst_align_err", align_err, 0);
            chk("rst_data_out", data_out, 0);
        end else begin
            chk("bitslip", bitslip, m_slip);
            chk("aligned", aligned, m_lock);
            chk("data_valid", data_valid, m_lock);
            chk("align_err", align_err, m_err);
            chk("data_out", data_out, m_dout);
        end
    end

    task automatic step_d(input logic [W-1:0] d);
        data_in = d;
        @(posedge clk);
        #1;
        if (rot_en && bitslip) clk_word = {clk_word[5:0], clk_word[6]};
    endtask

    task automatic step();
        step_d(W'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pll_lock = 1'b0; rot_en = 1'b0; clk_word = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lock(input string name, input int exp_steps);
        int n = 0;
        while (!aligned && n < 60) begin
            step();
            n++;
        end
        chk(name, n, exp_steps);
    endtask

    initial begin
        int n, slips, errs, first_err, ever_al, prev_bs, back2back;
        int slip_at[$];
        bit hits[12];
        bit exp_al[12];

        // Already aligned: 1 IDLE cycle plus 16 consecutive matches.
        do_reset();
        chk("reset_aligned", aligned, 0);
        chk("reset_data_out", data_out, 0);
        pll_lock = 1'b1; clk_word = PAT;
        n = 0; slips = 0;
        while (!aligned && n < 60) begin
            step(); n++;
            if (bitslip) slips++;
        end
        chk("lock_latency", n, 17);
        chk("no_slips_aligned", slips, 0);
        step_d(28'h0ABCDEF);
        chk("data_lag", data_out, 28'h0ABCDEF);
        chk("valid_locked", data_valid, 1);

        // Error tolerance while locked.
        hits   = '{0,0,0,1,0,0,0,1,0,0,0,0};
        exp_al = '{1,1,1,1,1,1,1,1,1,1,1,0};
        for (int i = 0; i < 12; i++) begin
            clk_word = hits[i] ? PAT : 7'b0000000;
            step();
            chk($sformatf("err_tol_%0d", i), aligned, exp_al[i]);
        end
        step();
        chk("slip_after_unlock", bitslip, 1);

        // PLL drop in LOCKED, then in VERIFY.
        clk_word = PAT;
        n = 0;
        while (!aligned && n < 60) begin step(); n++; end
        pll_lock = 1'b0;
        step();
        chk("pll_drop_locked_al", aligned, 0);
        chk("pll_drop_locked_do", data_out, 0);
        pll_lock = 1'b1;
        wait_lock("relock_after_locked_drop", 17);
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        repeat (5) step();
        pll_lock = 1'b0;
        step();
        chk("pll_drop_verify_al", aligned, 0);
        pll_lock = 1'b1;
        wait_lock("relock_after_verify_drop", 17);

        // Clock word rotated: three slips then lock.
        do_reset();
        pll_lock = 1'b1; clk_word = 7'b0111100; rot_en = 1'b1;
        n = 0;
        slip_at.delete();
        while (!aligned && n < 80) begin
            step(); n++;
            if (bitslip) slip_at.push_back(n);
        end
        chk("rot_slip_count", slip_at.size(), 3);
        if (slip_at.size() == 3) begin
            chk("rot_first_slip", slip_at[0], 2);
            chk("rot_spacing_1", slip_at[1] - slip_at[0], 6);
            chk("rot_spacing_2", slip_at[2] - slip_at[1], 6);
        end
        chk("rot_lock_step", n, 35);

        // No pattern ever.
        do_reset();
        pll_lock = 1'b1; clk_word = 7'b0000000;
        slips = 0; errs = 0; first_err = 0; ever_al = 0; prev_bs = 0; back2back = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (bitslip) slips++;
            if (bitslip && prev_bs) back2back++;
            prev_bs = bitslip;
            if (align_err) begin
                errs++;
                if (first_err == 0) first_err = i;
            end
            if (aligned) ever_al++;
        end
        chk("nopat_slips", slips, 17);
        chk("nopat_align_errs", errs, 2);
        chk("nopat_first_err", first_err, 39);
        chk("nopat_never_aligned", ever_al, 0);
        chk("nopat_no_back2back", back2back, 0);

        // Asynchronous reset in WAIT while align_err is high.
        do_reset();
        pll_lock = 1'b1; clk_word = 7'b0000000;
        repeat (39) step();
        chk("pre_reset_align_err", align_err, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_align_err", align_err, 0);
        chk("async_rst_bitslip", bitslip, 0);
        chk("async_rst_aligned", aligned, 0);
        chk("async_rst_valid", data_valid, 0);
        chk("async_rst_data_out", data_out, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        clk_word = PAT;
        @(posedge clk);
        #1;
        wait_lock("lock_after_async_reset", 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
